jtag_idcode_reader: RTL and testbench

//  Host-side JTAG master that reads a die's 32-bit IDCODE over the TAP pins.
//  On a start pulse it resets the TAP, loads the IDCODE instruction through an
//  IR scan, then runs a 32-bit DR scan and captures the returned identifier.
//  It sits in the SiP test controller and drives the die TAP. That TAP contains
//  the IDCODE register, which captures die_id in Capture-DR and shifts it LSB

---
 rtl/jtag_idcode_reader.sv | 150 +++++++++++++++
 tb/tb_jtag_idcode_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_idcode_reader.sv
// JTAG host master: resets the die TAP, loads the IDCODE instruction and
// shifts out the 32-bit identifier, reporting it with a one-cycle done pulse.
module jtag_idcode_reader #(
   parameter int unsigned       CLK_DIV   = 2,
   parameter int unsigned       IR_LEN    = 4,
   parameter logic [IR_LEN-1:0] IDCODE_IR = IR_LEN'(4'b0001)
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [31:0] idcode,
   output logic        id_err,
   output logic        TCK_O,
   output logic        TMS_O,
   output logic        TDI_O,
   input  logic        TDO_I
);

   localparam int unsigned ID_W     = 32;
   localparam int unsigned TLR_N    = 6;
   localparam int unsigned IR_N     = IR_LEN + 6;
   localparam int unsigned DR_N     = ID_W + 5;
   localparam int unsigned SLOT_MAX = (IR_N > DR_N) ? IR_N : DR_N;
   localparam int unsigned SLOT_W   = $clog2(SLOT_MAX);
   localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {S_IDLE, S_TLR, S_IR, S_DR, S_FINISH} state_t;

   state_t              state;
   state_t              nxt_state;
   logic [SLOT_W-1:0]   slot;
   logic [SLOT_W-1:0]   nxt_slot;
   logic [DIV_W-1:0]    div_cnt;
   logic [ID_W-1:0]     id_shift;
   logic [1:0]          nxt_bits;
   logic                last_slot;
   logic                shift_slot;

   // {TMS, TDI} driven during slot s of a scan phase
   function automatic logic [1:0] slot_bits(input state_t st, input logic [SLOT_W-1:0] s);
      logic [IR_LEN-1:0] ir_sh;
      logic              tms;
      logic              tdi;
      ir_sh = IDCODE_IR >> (s - SLOT_W'(4));
      tms   = 1'b0;
      tdi   = 1'b0;
      case (st)
         S_TLR: tms = (s != SLOT_W'(TLR_N - 1));
         S_IR: begin
            if (s < SLOT_W'(2)) begin
               tms = 1'b1;
            end else if (s >= SLOT_W'(4) && s < SLOT_W'(IR_LEN + 4)) begin
               tms = (s == SLOT_W'(IR_LEN + 3));
               tdi = ir_sh[0];
            end else if (s == SLOT_W'(IR_LEN + 4)) begin
               tms = 1'b1;
            end
         end
         S_DR: begin
            if (s == '0 || s == SLOT_W'(ID_W + 2) || s == SLOT_W'(ID_W + 3)) begin
               tms = 1'b1;
            end
         end
         default: ;
      endcase
      return {tms, tdi};
   endfunction

   // Slot sequencing across phases
   always_comb begin
      last_slot = 1'b0;
      nxt_state = state;
      nxt_slot  = slot + SLOT_W'(1);
      case (state)
         S_TLR: begin
            last_slot = (slot == SLOT_W'(TLR_N - 1));
            if (last_slot) nxt_state = S_IR;
         end
         S_IR: begin
            last_slot = (slot == SLOT_W'(IR_N - 1));
            if (last_slot) nxt_state = S_DR;
         end
         S_DR: begin
            last_slot = (slot == SLOT_W'(DR_N - 1));
            if (last_slot) nxt_state = S_FINISH;
         end
         default: ;
      endcase
      if (last_slot) nxt_slot = '0;
      nxt_bits   = slot_bits(nxt_state, nxt_slot);
      shift_slot = (state == S_DR) && (slot >= SLOT_W'(3)) && (slot <= SLOT_W'(ID_W + 2));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         slot     <= '0;
         div_cnt  <= '0;
         id_shift <= '0;
         TCK_O    <= 1'b0;
         TMS_O    <= 1'b1;
         TDI_O    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         idcode   <= '0;
         id_err   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // done still high means this is the completion cycle; ignore start
               if (start && !done) begin
                  state            <= S_TLR;
                  slot             <= '0;
                  div_cnt          <= '0;
                  busy             <= 1'b1;
                  {TMS_O, TDI_O}   <= slot_bits(S_TLR, '0);
               end
            end
            S_TLR, S_IR, S_DR: begin
               if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                  div_cnt <= '0;
                  if (!TCK_O) begin
                     TCK_O <= 1'b1;
                     if (shift_slot) id_shift <= {TDO_I, id_shift[ID_W-1:1]};
                  end else begin
                     TCK_O          <= 1'b0;
                     state          <= nxt_state;
                     slot           <= nxt_slot;
                     {TMS_O, TDI_O} <= nxt_bits;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            S_FINISH: begin
               idcode <= id_shift;
               id_err <= ~id_shift[0] | (&id_shift);
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_idcode_reader.sv
// Bench for jtag_idcode_reader: three readers (CLK_DIV 2/1/5), each driving a
// behavioural 16-state TAP holding a 4-bit IR and the die IDCODE register.
module tb_jtag_idcode_reader;

   typedef enum logic [3:0] {
      T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDR,
      T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
   } tap_t;

   logic        clk = 1'b0;
   logic        rst_a   [3];
   logic        start_a [3];
   logic        tie_a   [3];
   logic [31:0] die_a   [3];
   wire         busy_a  [3];
   wire         done_a  [3];
   wire  [31:0] idcode_a[3];
   wire         err_a   [3];
   wire         tck_a   [3];
   wire         tms_a   [3];
   wire         tdi_a   [3];
   wire         tdo_a   [3];
   wire  [3:0]  ir_a    [3];
   wire  [31:0] viol_a  [3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   function automatic tap_t tap_next(input tap_t s, input logic tms);
      case (s)
         T_TLR:   return tms ? T_TLR   : T_RTI;
         T_RTI:   return tms ? T_SELDR : T_RTI;
         T_SELDR: return tms ? T_SELIR : T_CAPDR;
         T_CAPDR: return tms ? T_EX1DR : T_SHDR;
         T_SHDR:  return tms ? T_EX1DR : T_SHDR;
         T_EX1DR: return tms ? T_UPDR  : T_PADR;
         T_PADR:  return tms ? T_EX2DR : T_PADR;
         T_EX2DR: return tms ? T_UPDR  : T_SHDR;
         T_UPDR:  return tms ? T_SELDR : T_RTI;
         T_SELIR: return tms ? T_TLR   : T_CAPIR;
         T_CAPIR: return tms ? T_EX1IR : T_SHIR;
         T_SHIR:  return tms ? T_EX1IR : T_SHIR;
         T_EX1IR: return tms ? T_UPIR  : T_PAIR;
         T_PAIR:  return tms ? T_EX2IR : T_PAIR;
         T_EX2IR: return tms ? T_UPIR  : T_SHIR;
         default: return tms ? T_SELDR : T_RTI;
      endcase
   endfunction

   function automatic int div_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 5);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gen_i
      localparam int D = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

      jtag_idcode_reader #(.CLK_DIV(D)) dut (
         .CLK    (clk),
         .RST    (rst_a[g]),
         .start  (start_a[g]),
         .busy   (busy_a[g]),
         .done   (done_a[g]),
         .idcode (idcode_a[g]),
         .id_err (err_a[g]),
         .TCK_O  (tck_a[g]),
         .TMS_O  (tms_a[g]),
         .TDI_O  (tdi_a[g]),
         .TDO_I  (tdo_a[g])
      );

      tap_t        st    = T_TLR;
      logic [3:0]  ir    = 4'hF;
      logic [3:0]  ir_sr = 4'h0;
      logic [31:0] dr    = 32'h0;

      // Die TAP: acts on the rising TCK edge
      always @(posedge tck_a[g]) begin
         case (st)
            T_TLR:   ir    <= 4'hF;
            T_CAPIR: ir_sr <= 4'b0101;
            T_SHIR:  ir_sr <= {tdi_a[g], ir_sr[3:1]};
            T_UPIR:  ir    <= ir_sr;
            T_CAPDR: dr    <= (ir == 4'b0001) ? die_a[g] : 32'h0;
            T_SHDR:  dr    <= {tdi_a[g], dr[31:1]};
            default: ;
         endcase
         st <= tap_next(st, tms_a[g]);
      end

      assign tdo_a[g] = tie_a[g] ? 1'b1 : (st == T_SHDR) ? dr[0] : (st == T_SHIR) ? ir_sr[0] : 1'b0;
      assign ir_a[g]  = ir;

      int   lo = 0, hi = 0, viol = 0;
      logic p_tck = 1'b0, p_tms = 1'b1, p_tdi = 1'b0;

      // TMS/TDI stable across TCK rise; every TCK half-phase lasts D cycles
      always @(negedge clk) begin
         if (tck_a[g] === 1'b1 && p_tck === 1'b0 && (tms_a[g] !== p_tms || tdi_a[g] !== p_tdi))
            viol++;
         if (busy_a[g] !== 1'b1) begin
            lo = 0;
            hi = 0;
         end else if (tck_a[g] === 1'b1) begin
            if (lo != 0) begin
               if (lo != D) viol++;
               lo = 0;
            end
            hi++;
         end else begin
            if (hi != 0) begin
               if (hi != D) viol++;
               hi = 0;
            end
            lo++;
         end
         p_tck = tck_a[g];
         p_tms = tms_a[g];
         p_tdi = tdi_a[g];
      end
      assign viol_a[g] = 32'(viol);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse start at a negedge; returns at the negedge after the accept edge
   task automatic start_scan(input int g);
      start_a[g] = 1'b1;
      @(negedge clk);
      start_a[g] = 1'b0;
      check("busy_after_accept", 32'(busy_a[g]), 32'd1);
   endtask

   task automatic wait_done(input int g, input bit extra, output int n);
      n = 0;
      while (done_a[g] !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
         if (extra) start_a[g] = (n == 49) || (n >= 211);
      end
   endtask

   task automatic finish_check(input int g, input int n, input logic [31:0] exp_id, input string tag);
      logic exp_err;
      exp_err = (exp_id[0] == 1'b0) || (exp_id == 32'hFFFF_FFFF);
      check({tag, "_latency"}, 32'(n), 32'(106 * div_of(g) + 1));
      check({tag, "_idcode"}, idcode_a[g], exp_id);
      check({tag, "_id_err"}, 32'(err_a[g]), 32'(exp_err));
      check({tag, "_busy_at_done"}, 32'(busy_a[g]), 32'd0);
      check({tag, "_ir_loaded"}, 32'(ir_a[g]), 32'h1);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'(done_a[g]), 32'd0);
   endtask

   task automatic do_scan(input int g, input logic [31:0] id, input bit tie, input string tag);
      int n;
      die_a[g] = id;
      tie_a[g] = tie;
      start_scan(g);
      wait_done(g, 1'b0, n);
      finish_check(g, n, tie ? 32'hFFFF_FFFF : id, tag);
      tie_a[g] = 1'b0;
   endtask

   initial begin
      int n;
      int ndone;
      int nbusy;
      logic [31:0] rid;

      for (int g = 0; g < 3; g++) begin
         rst_a[g]   = 1'b1;
         start_a[g] = 1'b0;
         tie_a[g]   = 1'b0;
         die_a[g]   = 32'h0;
      end
      repeat (3) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         check("rst_tck",    32'(tck_a[g]),  32'd0);
         check("rst_tms",    32'(tms_a[g]),  32'd1);
         check("rst_tdi",    32'(tdi_a[g]),  32'd0);
         check("rst_busy",   32'(busy_a[g]), 32'd0);
         check("rst_done",   32'(done_a[g]), 32'd0);
         check("rst_idcode", idcode_a[g],    32'd0);
         check("rst_id_err", 32'(err_a[g]),  32'd0);
         rst_a[g] = 1'b0;
      end
      @(negedge clk);

      // Abort a scan with RST at cycle 100
      die_a[0] = 32'h1234_5A5B;
      start_scan(0);
      repeat (99) @(negedge clk);
      rst_a[0] = 1'b1;
      @(negedge clk);
      rst_a[0] = 1'b0;
      check("abort_tck",    32'(tck_a[0]),  32'd0);
      check("abort_tms",    32'(tms_a[0]),  32'd1);
      check("abort_busy",   32'(busy_a[0]), 32'd0);
      check("abort_idcode", idcode_a[0],    32'd0);
      ndone = 0;
      nbusy = 0;
      repeat (250) begin
         @(negedge clk);
         if (done_a[0] === 1'b1) ndone++;
         if (busy_a[0] === 1'b1) nbusy++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);
      check("abort_idle",    32'(nbusy), 32'd0);

      do_scan(0, 32'h1234_5A5B, 1'b0, "basic");
      do_scan(0, 32'h0000_0002, 1'b0, "bit0_clear");
      do_scan(0, 32'h0000_0000, 1'b1, "tdo_tied1");

      // Starts during busy, at FINISH and with done are ignored; the next one is taken
      die_a[0] = 32'hC0DE_1235;
      start_scan(0);
      wait_done(0, 1'b1, n);
      check("restart_latency", 32'(n), 32'd213);
      check("restart_idcode",  idcode_a[0], 32'hC0DE_1235);
      @(negedge clk);
      check("restart_done_once", 32'(done_a[0]), 32'd0);
      check("restart_ignored",   32'(busy_a[0]), 32'd0);
      die_a[0] = 32'h8765_4321;
      @(negedge clk);
      start_a[0] = 1'b0;
      check("second_accept", 32'(busy_a[0]), 32'd1);
      wait_done(0, 1'b0, n);
      finish_check(0, n, 32'h8765_4321, "second_scan");

      for (int g = 0; g < 3; g++) begin
         for (int k = 0; k < 3; k++) begin
            rid = $urandom;
            if (k == 0) rid[0] = 1'b1;
            do_scan(g, rid, 1'b0, $sformatf("rand_g%0d_k%0d", g, k));
         end
      end

      check("tck_timing_div2", viol_a[0], 32'd0);
      check("tck_timing_div1", viol_a[1], 32'd0);
      check("tck_timing_div5", viol_a[2], 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
